// File: rtl/hazard_stall_controller.sv
// Hazard/stall producer: load-use, branch-on-EX/MEM and dmem-wait controls,
// plus stall and flush performance counters.
module hazard_stall_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic             ID_UsesRs1,
  input  logic             ID_UsesRs2,
  input  logic             ID_IsBranch,
  input  logic             ID_BranchTaken,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rd,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_Rd,
  input  logic             dmem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             Pipe_Freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, HAZ_STALL} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [1:0]       r_cnt;
  logic [1:0]       w_cnt_nx;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_ex_match;
  logic             w_mem_match;
  logic [1:0]       w_need;

  assign w_ex_match = (EX_Rd != 5'd0) &&
                      ((ID_UsesRs1 && ID_Rs1 == EX_Rd) ||
                       (ID_UsesRs2 && ID_Rs2 == EX_Rd));

  assign w_mem_match = (MEM_Rd != 5'd0) &&
                       ((ID_UsesRs1 && ID_Rs1 == MEM_Rd) ||
                        (ID_UsesRs2 && ID_Rs2 == MEM_Rd));

  // Largest applicable term wins, so the 2-cycle case is tested first.
  always_comb begin
    w_need = 2'd0;
    if (ID_IsBranch && EX_MemRead && w_ex_match)
      w_need = 2'd2;
    else if (EX_MemRead && w_ex_match)
      w_need = 2'd1;
    else if (ID_IsBranch && EX_RegWrite && w_ex_match)
      w_need = 2'd1;
    else if (ID_IsBranch && MEM_MemRead && w_mem_match)
      w_need = 2'd1;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    Pipe_Freeze  = 1'b0;
    if (!dmem_ready) begin
      Pipe_Freeze = 1'b1;
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
    end else if (r_state == HAZ_STALL) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      w_cnt_nx     = r_cnt - 2'd1;
      if (r_cnt == 2'd1)
        w_state_nx = RUN;
    end else if (w_need != 2'd0) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      if (w_need == 2'd2) begin
        w_state_nx = HAZ_STALL;
        w_cnt_nx   = 2'd1;
      end
    end else begin
      IF_ID_Flush = ID_BranchTaken && ID_IsBranch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_cnt          <= 2'd0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state        <= w_state_nx;
      r_cnt          <= w_cnt_nx;
      r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, ~PC_Write};
      r_flush_count  <= r_flush_count + {{(CNT_W-1){1'b0}}, IF_ID_Flush};
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule
